// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, responder FSM states and wait-state ceiling.
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package wb_pkg;
  localparam int ADDR_W      = `ADDR_SIZE;
  localparam int WORD_W      = `WORD_SIZE;
  localparam int WB_MAX_WAIT = 15;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_WAIT = 2'd1,
    WB_RESP = 2'd2
  } wb_resp_state_t;

  // Saturate a requested wait-state count into the 4-bit counter range.
  function automatic logic [3:0] wait_load(input int ws);
    if (ws > WB_MAX_WAIT) begin
      wait_load = 4'(WB_MAX_WAIT);
    end else if (ws < 0) begin
      wait_load = 4'd0;
    end else begin
      wait_load = 4'(ws);
    end
  endfunction
endpackage

// File: rtl/wb_mem_array.sv
// Single-port synchronous word RAM; the read register returns zero whenever no read is issued.
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic [WORD_W-1:0] rdata_r;

  // Storage write port; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[idx] <= wdata;
    end
  end

  // Read register doubles as the bus data output, so it is cleared outside read cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {WORD_W{1'b0}};
    end else if (rd_en) begin
      rdata_r <= mem_r[idx];
    end else begin
      rdata_r <= {WORD_W{1'b0}};
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone-style memory responder: window decode, wait-state FSM, and ack/err generation
// in front of an internal word RAM.
module wb_mem_responder
  import wb_pkg::*;
#(
  parameter int               DEPTH       = 256,
  parameter int               WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = {ADDR_W{1'b0}}
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] Wb_addr,
  input  logic              Wb_cs,
  input  logic              Wb_we,
  input  logic [WORD_W-1:0] Wb_wdata,
  output logic [WORD_W-1:0] Wb_rdata,
  output logic              Wb_ack,
  output logic              Wb_err
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = wait_load(WAIT_STATES);

  wb_resp_state_t    state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              accept_s;
  logic              rd_en_s;
  logic              wr_en_s;

  logic [ADDR_W-1:0] offset_s;
  logic              hit_s;
  logic [IDX_W-1:0]  idx_s;

  logic              we_r;
  logic              hit_r;
  logic [IDX_W-1:0]  idx_r;
  logic [WORD_W-1:0] wdata_r;
  logic              ack_r;
  logic              err_r;

  // Window decode relies on unsigned wrap so addresses below BASE_ADDR also miss.
  always_comb begin
    offset_s = Wb_addr - BASE_ADDR;
    hit_s    = (offset_s < ADDR_W'(DEPTH));
    idx_s    = offset_s[IDX_W-1:0];
  end

  // Next-state logic; a dropped Wb_cs aborts only while still waiting.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    rd_en_s  = 1'b0;
    case (state_r)
      WB_IDLE: begin
        if (Wb_cs) begin
          accept_s = 1'b1;
          cnt_s    = WAIT_INIT;
          state_s  = WB_WAIT;
        end else begin
          state_s  = WB_IDLE;
        end
      end
      WB_WAIT: begin
        if (!Wb_cs) begin
          state_s = WB_IDLE;
        end else if (cnt_r != 4'd0) begin
          cnt_s   = cnt_r - 4'd1;
        end else begin
          rd_en_s = hit_r & ~we_r;
          state_s = WB_RESP;
        end
      end
      WB_RESP: begin
        state_s = WB_IDLE;
      end
      default: begin
        state_s = WB_IDLE;
      end
    endcase
  end

  // Write commits on the edge that closes the response cycle.
  always_comb begin
    wr_en_s = 1'b0;
    if (state_r == WB_RESP) begin
      wr_en_s = hit_r & we_r;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // FSM state and wait counter.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= WB_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request latch: bus inputs are only honoured at acceptance.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      we_r    <= 1'b0;
      hit_r   <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
      wdata_r <= {WORD_W{1'b0}};
    end else if (accept_s) begin
      we_r    <= Wb_we;
      hit_r   <= hit_s;
      idx_r   <= idx_s;
      wdata_r <= Wb_wdata;
    end else begin
      we_r    <= we_r;
      hit_r   <= hit_r;
      idx_r   <= idx_r;
      wdata_r <= wdata_r;
    end
  end

  // Completion pulses are registered so they line up with the RAM read data.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      ack_r <= (state_s == WB_RESP) &  hit_r;
      err_r <= (state_s == WB_RESP) & ~hit_r;
    end
  end

  wb_mem_array #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (Clk),
    .rst_n (Rst_n),
    .rd_en (rd_en_s),
    .wr_en (wr_en_s),
    .idx   (idx_r),
    .wdata (wdata_r),
    .rdata (Wb_rdata)
  );

  assign Wb_ack = ack_r;
  assign Wb_err = err_r;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: three instances with different wait states and windows.
module tb_wb_mem_responder;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [31:0] Wb_addr;
  logic [31:0] Wb_wdata;
  logic        Wb_we;
  logic        cs    [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] rdata [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  // sel 0: no wait states, window 256..511
  wb_mem_responder #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'd256)) dut0 (
    .Clk(Clk), .Rst_n(Rst_n), .Wb_addr(Wb_addr), .Wb_cs(cs[0]), .Wb_we(Wb_we),
    .Wb_wdata(Wb_wdata), .Wb_rdata(rdata[0]), .Wb_ack(ack[0]), .Wb_err(err[0]));

  // sel 1: three wait states, window 0..255
  wb_mem_responder #(.DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'd0)) dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .Wb_addr(Wb_addr), .Wb_cs(cs[1]), .Wb_we(Wb_we),
    .Wb_wdata(Wb_wdata), .Wb_rdata(rdata[1]), .Wb_ack(ack[1]), .Wb_err(err[1]));

  // sel 2: four wait states, window 512..767
  wb_mem_responder #(.DEPTH(256), .WAIT_STATES(4), .BASE_ADDR(32'd512)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Wb_addr(Wb_addr), .Wb_cs(cs[2]), .Wb_we(Wb_we),
    .Wb_wdata(Wb_wdata), .Wb_rdata(rdata[2]), .Wb_ack(ack[2]), .Wb_err(err[2]));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input int sel, input string tag);
    chk({tag, "_ack"},   32'(ack[sel]), 32'd0);
    chk({tag, "_err"},   32'(err[sel]), 32'd0);
    chk({tag, "_rdata"}, rdata[sel],    32'd0);
  endtask

  // One transaction; lat = cycles from call to the expected completion cycle.
  task automatic txn(input int sel, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic miss, input logic [31:0] exp_rd,
                     input int lat, input logic keep, input string tag);
    Wb_we    = we;
    Wb_addr  = addr;
    Wb_wdata = wd;
    cs[sel]  = 1'b1;
    for (int i = 1; i < lat; i++) begin
      step();
      chk_quiet(sel, {tag, "_pre"});
    end
    step();
    chk({tag, "_ack"},   32'(ack[sel]), miss ? 32'd0 : 32'd1);
    chk({tag, "_err"},   32'(err[sel]), miss ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, rdata[sel],    (miss || we) ? 32'd0 : exp_rd);
    if (!keep) begin
      cs[sel] = 1'b0;
      step();
      chk_quiet(sel, {tag, "_post"});
    end
  endtask

  initial begin
    Rst_n    = 1'b0;
    Wb_addr  = 32'd0;
    Wb_wdata = 32'd0;
    Wb_we    = 1'b0;
    for (int i = 0; i < 3; i++) cs[i] = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) chk_quiet(i, "reset");
    Rst_n = 1'b1;
    step();

    // zero wait states: write then read back, completion two cycles after the request
    txn(0, 1'b1, 32'd261, 32'hDEAD_BEEF, 1'b0, 32'd0,         2, 1'b0, "ws0_wr");
    txn(0, 1'b0, 32'd261, 32'd0,         1'b0, 32'hDEAD_BEEF, 2, 1'b0, "ws0_rd");

    // out-of-window: BASE+DEPTH aliases index 0 if decode were truncated
    txn(0, 1'b1, 32'd256, 32'hA5A5_0000, 1'b0, 32'd0,         2, 1'b0, "base0_wr");
    txn(0, 1'b1, 32'd512, 32'h1234_5678, 1'b1, 32'd0,         2, 1'b0, "miss_wr");
    txn(0, 1'b0, 32'd256, 32'd0,         1'b0, 32'hA5A5_0000, 2, 1'b0, "base0_rd");
    txn(0, 1'b0, 32'd255, 32'd0,         1'b1, 32'd0,         2, 1'b0, "miss_rd_below");

    // three wait states: ack exactly five cycles after the request, single pulse
    txn(1, 1'b1, 32'd7, 32'h0BAD_F00D, 1'b0, 32'd0,         5, 1'b0, "ws3_wr");
    txn(1, 1'b0, 32'd7, 32'd0,         1'b0, 32'h0BAD_F00D, 5, 1'b0, "ws3_rd");

    // abort: drop Wb_cs mid-wait, no completion, no write
    txn(2, 1'b1, 32'd514, 32'h1111_2222, 1'b0, 32'd0, 6, 1'b0, "ws4_wr");
    Wb_we    = 1'b1;
    Wb_addr  = 32'd514;
    Wb_wdata = 32'h3333_4444;
    cs[2]    = 1'b1;
    step();
    step();
    cs[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_quiet(2, "abort_quiet");
    end
    txn(2, 1'b0, 32'd514, 32'd0, 1'b0, 32'h1111_2222, 6, 1'b0, "abort_rd");

    // back-to-back: Wb_cs held through ack, next request seen the cycle after
    txn(0, 1'b1, 32'd266, 32'hCAFE_0001, 1'b0, 32'd0,         2, 1'b1, "b2b_w1");
    txn(0, 1'b1, 32'd267, 32'hCAFE_0002, 1'b0, 32'd0,         3, 1'b0, "b2b_w2");
    txn(0, 1'b0, 32'd266, 32'd0,         1'b0, 32'hCAFE_0001, 2, 1'b1, "b2b_r1");
    txn(0, 1'b0, 32'd267, 32'd0,         1'b0, 32'hCAFE_0002, 3, 1'b0, "b2b_r2");

    // asynchronous reset while an ack is on the bus
    Wb_we   = 1'b0;
    Wb_addr = 32'd261;
    cs[0]   = 1'b1;
    step();
    step();
    chk("rst_resp_ack_before", 32'(ack[0]), 32'd1);
    chk("rst_resp_rdata_before", rdata[0], 32'hDEAD_BEEF);
    Rst_n = 1'b0;
    #1;
    chk_quiet(0, "rst_resp_async");
    cs[0] = 1'b0;
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_quiet(0, "rst_resp_after");
    end

    // asynchronous reset mid-wait drops the pending write
    txn(2, 1'b1, 32'd515, 32'h0101_0101, 1'b0, 32'd0, 6, 1'b0, "ws4_pre_wr");
    Wb_we    = 1'b1;
    Wb_addr  = 32'd515;
    Wb_wdata = 32'h7777_8888;
    cs[2]    = 1'b1;
    step();
    step();
    Rst_n = 1'b0;
    #1;
    chk_quiet(2, "rst_wait_async");
    cs[2] = 1'b0;
    step();
    Rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_quiet(2, "rst_wait_after");
    end
    txn(2, 1'b0, 32'd515, 32'd0, 1'b0, 32'h0101_0101, 6, 1'b0, "rst_wait_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
